// File: rtl/active_list_commit_reader.sv
// In-order retirement reader for the active-list head: decides how many head
// entries retire each cycle and raises one recovery/exception request on a fault.
module active_list_commit_reader #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PREG_NUM_BIT = 7,
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 64,
  localparam int POP_W       = $clog2(COMMIT_WIDTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [COMMIT_WIDTH-1:0]          headValid,
  input  logic [COMMIT_WIDTH-1:0]          headExecuted,
  input  logic [COMMIT_WIDTH-1:0]          headException,
  input  logic [COMMIT_WIDTH-1:0]          headMispred,
  input  logic [COMMIT_WIDTH-1:0]          headIsStore,
  input  logic [COMMIT_WIDTH-1:0]          headWriteReg,
  input  logic [COMMIT_WIDTH*PREG_NUM_BIT-1:0] headPrevDstReg,
  input  logic [COMMIT_WIDTH*PC_WIDTH-1:0] headPc,
  input  logic                             recoveryDone,
  output logic [POP_W-1:0]                 popCount,
  output logic [COMMIT_WIDTH-1:0]          releaseValid,
  output logic [COMMIT_WIDTH*PREG_NUM_BIT-1:0] releaseReg,
  output logic [COMMIT_WIDTH-1:0]          storeCommit,
  output logic                             recoveryReq,
  output logic                             exceptionReq,
  output logic [PC_WIDTH-1:0]              recoveryPc,
  output logic [CNT_WIDTH-1:0]             retiredCount,
  output logic                             busy,
  output logic [0:0]                       state_dbg
);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] RECOVER = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_nxt;
  logic                go;
  logic                ev_mispred;
  logic                ev_exception;
  logic [PC_WIDTH-1:0] ev_pc;

  // Handshake: there is no ready. popCount and the per-lane strobes are valid in
  // the same cycle as the head inputs; the active list and free list act on them
  // at the next clock edge unconditionally.
  always_comb begin
    popCount     = '0;
    releaseValid = '0;
    releaseReg   = '0;
    storeCommit  = '0;
    ev_mispred   = 1'b0;
    ev_exception = 1'b0;
    ev_pc        = '0;
    go           = rst && (state == NORMAL) && !stall;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (go) begin
        if (headValid[i] && headExecuted[i]) begin
          if (headException[i]) begin
            ev_exception = 1'b1;
            ev_pc        = headPc[i*PC_WIDTH +: PC_WIDTH];
            go           = 1'b0;
          end else begin
            popCount        = POP_W'(i + 1);
            releaseValid[i] = headWriteReg[i];
            releaseReg[i*PREG_NUM_BIT +: PREG_NUM_BIT] =
              headPrevDstReg[i*PREG_NUM_BIT +: PREG_NUM_BIT];
            storeCommit[i]  = headIsStore[i];
            // A mispredicted branch retires itself but blocks all younger lanes.
            if (headMispred[i]) begin
              ev_mispred = 1'b1;
              ev_pc      = headPc[i*PC_WIDTH +: PC_WIDTH];
              go         = 1'b0;
            end
          end
        end else begin
          go = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NORMAL:  if (ev_mispred || ev_exception) state_nxt = RECOVER;
      RECOVER: if (recoveryDone)               state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= NORMAL;
      recoveryReq  <= 1'b0;
      exceptionReq <= 1'b0;
      recoveryPc   <= '0;
      retiredCount <= '0;
    end else begin
      state        <= state_nxt;
      recoveryReq  <= ev_mispred;
      exceptionReq <= ev_exception;
      if (ev_mispred || ev_exception) recoveryPc <= ev_pc;
      retiredCount <= retiredCount + {{(CNT_WIDTH-POP_W){1'b0}}, popCount};
    end
  end

  assign busy      = (state == RECOVER);
  assign state_dbg = state;

endmodule

// File: tb/tb_active_list_commit_reader.sv
// Randomized scoreboard bench for active_list_commit_reader against a lane-scan
// reference model; a narrow-counter instance exercises retiredCount wrap.
module tb_active_list_commit_reader;
  localparam int W   = 2;
  localparam int PB  = 7;
  localparam int PCW = 32;
  localparam int CW  = 64;
  localparam int SCW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic [W-1:0] headValid = '0, headExecuted = '0, headException = '0;
  logic [W-1:0] headMispred = '0, headIsStore = '0, headWriteReg = '0;
  logic [W*PB-1:0] headPrevDstReg = '0;
  logic [W*PCW-1:0] headPc = '0;
  logic recoveryDone = 1'b0;

  logic [1:0] popCount, s_popCount;
  logic [W-1:0] releaseValid, storeCommit, s_releaseValid, s_storeCommit;
  logic [W*PB-1:0] releaseReg, s_releaseReg;
  logic recoveryReq, exceptionReq, busy, s_recoveryReq, s_exceptionReq, s_busy;
  logic [PCW-1:0] recoveryPc, s_recoveryPc;
  logic [CW-1:0] retiredCount;
  logic [SCW-1:0] s_retiredCount;
  logic [0:0] state_dbg, s_state_dbg;

  always #5 clk = ~clk;

  active_list_commit_reader #(.COMMIT_WIDTH(W), .PREG_NUM_BIT(PB), .PC_WIDTH(PCW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .headValid(headValid), .headExecuted(headExecuted),
    .headException(headException), .headMispred(headMispred), .headIsStore(headIsStore),
    .headWriteReg(headWriteReg), .headPrevDstReg(headPrevDstReg), .headPc(headPc),
    .recoveryDone(recoveryDone), .popCount(popCount), .releaseValid(releaseValid),
    .releaseReg(releaseReg), .storeCommit(storeCommit), .recoveryReq(recoveryReq),
    .exceptionReq(exceptionReq), .recoveryPc(recoveryPc), .retiredCount(retiredCount),
    .busy(busy), .state_dbg(state_dbg));

  active_list_commit_reader #(.COMMIT_WIDTH(W), .PREG_NUM_BIT(PB), .PC_WIDTH(PCW), .CNT_WIDTH(SCW)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .headValid(headValid), .headExecuted(headExecuted),
    .headException(headException), .headMispred(headMispred), .headIsStore(headIsStore),
    .headWriteReg(headWriteReg), .headPrevDstReg(headPrevDstReg), .headPc(headPc),
    .recoveryDone(recoveryDone), .popCount(s_popCount), .releaseValid(s_releaseValid),
    .releaseReg(s_releaseReg), .storeCommit(s_storeCommit), .recoveryReq(s_recoveryReq),
    .exceptionReq(s_exceptionReq), .recoveryPc(s_recoveryPc), .retiredCount(s_retiredCount),
    .busy(s_busy), .state_dbg(s_state_dbg));

  typedef struct packed {
    logic [1:0]    pop;
    logic [W-1:0]  relv;
    logic [W*PB-1:0] relreg;
    logic [W-1:0]  store;
    logic          rreq;
    logic          ereq;
    logic [PCW-1:0] pc;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [SCW-1:0] scnt;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (values visible in the current cycle)
  bit            m_rec  = 1'b0;
  logic          m_rreq = 1'b0;
  logic          m_ereq = 1'b0;
  logic [PCW-1:0] m_pc  = '0;
  logic [CW-1:0] m_cnt  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic drive(input logic r, input logic st, input logic [W-1:0] v, input logic [W-1:0] ex,
                       input logic [W-1:0] exc, input logic [W-1:0] mis, input logic [W-1:0] sto,
                       input logic [W-1:0] wr, input logic [W*PB-1:0] prev,
                       input logic [W*PCW-1:0] pcs, input logic done);
    exp_t e;
    int n;
    bit ev_m, ev_e;
    logic [PCW-1:0] ev_pc;
    @(posedge clk);
    #1;
    rst = r; stall = st; headValid = v; headExecuted = ex; headException = exc;
    headMispred = mis; headIsStore = sto; headWriteReg = wr; headPrevDstReg = prev;
    headPc = pcs; recoveryDone = done;

    e = '0;
    if (r) begin
      e.rreq = m_rreq; e.ereq = m_ereq; e.pc = m_pc; e.busy = m_rec;
      e.cnt = m_cnt; e.scnt = m_cnt[SCW-1:0];
    end
    n = 0; ev_m = 1'b0; ev_e = 1'b0; ev_pc = '0;
    if (r && !m_rec && !st) begin
      // leading run of finished, non-faulting entries
      while (n < W && v[n] && ex[n] && !exc[n]) n++;
      // the oldest mispredicted branch in that run ends it, inclusive
      for (int i = 0; i < W; i++)
        if (!ev_m && i < n && mis[i]) begin
          n = i + 1; ev_m = 1'b1; ev_pc = pcs[i*PCW +: PCW];
        end
      if (!ev_m && n < W && v[n] && ex[n] && exc[n]) begin
        ev_e = 1'b1; ev_pc = pcs[n*PCW +: PCW];
      end
    end
    e.pop = 2'(n);
    for (int i = 0; i < W; i++)
      if (i < n) begin
        e.relv[i] = wr[i];
        e.relreg[i*PB +: PB] = prev[i*PB +: PB];
        e.store[i] = sto[i];
      end
    exp_q.push_back(EXP_W'(e));

    if (!r) begin
      m_rec = 1'b0; m_rreq = 1'b0; m_ereq = 1'b0; m_pc = '0; m_cnt = '0;
    end else begin
      m_cnt  = m_cnt + CW'(n);
      m_rreq = ev_m;
      m_ereq = ev_e;
      if (ev_m || ev_e) begin
        m_pc = ev_pc; m_rec = 1'b1;
      end else if (m_rec && done) begin
        m_rec = 1'b0;
      end
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  exp_t mon_e;
  logic [W*PB-1:0] rr_mask;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_t'(exp_q.pop_front());
      rr_mask = '0;
      for (int i = 0; i < W; i++) if (mon_e.relv[i]) rr_mask[i*PB +: PB] = '1;
      check("popCount", 64'(popCount), 64'(mon_e.pop));
      check("releaseValid", 64'(releaseValid), 64'(mon_e.relv));
      check("releaseReg", 64'(releaseReg & rr_mask), 64'(mon_e.relreg & rr_mask));
      check("storeCommit", 64'(storeCommit), 64'(mon_e.store));
      check("recoveryReq", 64'(recoveryReq), 64'(mon_e.rreq));
      check("exceptionReq", 64'(exceptionReq), 64'(mon_e.ereq));
      check("recoveryPc", 64'(recoveryPc), 64'(mon_e.pc));
      check("busy", 64'(busy), 64'(mon_e.busy));
      check("state_dbg", 64'(state_dbg), 64'(mon_e.busy));
      check("retiredCount", retiredCount, mon_e.cnt);
      check("retiredCount_wrap", 64'(s_retiredCount), 64'(mon_e.scnt));
    end
  end

  localparam logic [W*PCW-1:0] PC_A = {32'h0000_0104, 32'h0000_0100};

  initial begin
    logic [W-1:0] rv;
    int k;
    // reset
    drive(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd9, 7'd5}, PC_A, 0);
    drive(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 0);
    // two ALU ops retire
    drive(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd9, 7'd5}, PC_A, 0);
    // partial head, then the remaining entry
    drive(1, 0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, {7'd12, 7'd3}, PC_A, 0);
    drive(1, 0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, {7'd0, 7'd12}, PC_A, 0);
    // empty list
    drive(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 0);
    // mispredict at 0x1000, held in RECOVER, then resume
    drive(1, 0, 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 2'b11, {7'd20, 7'd21}, {32'h1004, 32'h1000}, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd20, 7'd22}, {32'h1104, 32'h1100}, 0);
    drive(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd20, 7'd22}, {32'h1104, 32'h1100}, 1);
    drive(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd20, 7'd22}, {32'h1104, 32'h1100}, 0);
    // retiring store, then exception at 0x2004
    drive(1, 0, 2'b11, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00, {7'd1, 7'd2}, {32'h2004, 32'h2000}, 0);
    drive(1, 0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, '0, {32'h2008, 32'h2004}, 1);
    // exception and mispredict on one lane: exception wins
    drive(1, 0, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11, '0, {32'h3004, 32'h3000}, 0);
    drive(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 1);
    // stall with all lanes ready
    drive(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd4, 7'd6}, PC_A, 0);
    // reset asserted during RECOVER
    drive(1, 0, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, {7'd0, 7'd7}, {32'h0, 32'h4000}, 0);
    drive(0, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd4, 7'd6}, PC_A, 0);
    drive(1, 0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, {7'd4, 7'd6}, PC_A, 0);
    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      k  = $urandom_range(0, W);
      rv = W'((1 << k) - 1);
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0), rv,
            W'($urandom_range(0, 3) | ($urandom_range(0, 1) ? 3 : 0)),
            W'(($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0),
            W'(($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0),
            W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
            (W*PB)'($urandom), {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
    end
    drive(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 0);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/active_list_commit_reader.md
# active_list_commit_reader

In-order retirement reader at the head end of the active list. The rename stage writes entries into the active list. This block inspects up to COMMIT_WIDTH head entries each cycle and decides how many retire. For each retired entry it pops the entry, releases the previous physical destination register, and signals store commits. On a mispredicted branch or a faulting op it raises a single recovery or exception request, then holds retirement until the recovery manager reports completion.

## Interface
Parameters:
- COMMIT_WIDTH, 2, head lanes inspected per cycle (lane 0 = oldest).
- PREG_NUM_BIT, 7, physical register number width.
- PC_WIDTH, 32, program counter width.
- CNT_WIDTH, 64, retired-op counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  suppress all retirement this cycle.
- headValid  in  COMMIT_WIDTH  lane holds a live entry; lanes are contiguous from lane 0.
- headExecuted  in  COMMIT_WIDTH  lane has finished execution.
- headException  in  COMMIT_WIDTH  lane is undefined or faulted.
- headMispred  in  COMMIT_WIDTH  lane is a mispredicted branch.
- headIsStore  in  COMMIT_WIDTH  lane is a store.
- headWriteReg  in  COMMIT_WIDTH  lane writes a register.
- headPrevDstReg  in  COMMIT_WIDTH*PREG_NUM_BIT  previous physical destination per lane.
- headPc  in  COMMIT_WIDTH*PC_WIDTH  PC per lane.
- recoveryDone  in  1  recovery manager has finished the flush.
- popCount  out  $clog2(COMMIT_WIDTH+1)  entries popped at the next edge.
- releaseValid  out  COMMIT_WIDTH  free-list release strobe per lane.
- releaseReg  out  COMMIT_WIDTH*PREG_NUM_BIT  register released per lane.
- storeCommit  out  COMMIT_WIDTH  store in this lane commits to the store queue.
- recoveryReq  out  1  one-cycle pulse: mispredict recovery.
- exceptionReq  out  1  one-cycle pulse: exception recovery.
- recoveryPc  out  PC_WIDTH  PC of the offending op, valid with either pulse.
- retiredCount  out  CNT_WIDTH  total ops retired since reset.
- busy  out  1  high while in RECOVER.

## Operation
- States: NORMAL and RECOVER.
- Lane i retires when all of the following hold:
  - state is NORMAL and stall is low;
  - all lanes below i retire;
  - headValid[i] and headExecuted[i] are high;
  - headException[i] is low;
  - no lane below i retired as a mispredicted branch.
- Mispredicted branch: the branch retires, including its release and store signals. No younger lane retires that cycle. The next state is RECOVER, and recoveryReq pulses with recoveryPc set to the branch PC.
- Exception: the first non-retiring lane k has headValid, headExecuted and headException high, and all lanes below k retired. Lane k does not retire. The next state is RECOVER, and exceptionReq pulses with recoveryPc = headPc[k].
- An unexecuted lane stops retirement at that lane and raises no request. This also applies to exceptions or mispredicts on younger lanes.
- The oldest qualifying event wins. On a single lane with both headException and headMispred high, the exception wins.
- Per retiring lane:
  - releaseValid[i] = headWriteReg[i];
  - releaseReg[i] = headPrevDstReg[i];
  - storeCommit[i] = headIsStore[i].
- Non-retiring lanes drive zero on releaseValid and storeCommit.
- popCount is the number of retiring lanes. retiredCount adds popCount at each edge and wraps modulo 2^CNT_WIDTH.
- RECOVER:
  - popCount, releaseValid and storeCommit are forced to 0.
  - On recoveryDone sampled high, the next state is NORMAL.
  - recoveryDone is ignored in NORMAL.
  - stall has no effect in RECOVER.

## Timing
- The retirement decision and the outputs popCount, releaseValid, releaseReg and storeCommit are combinational from the head inputs in the same cycle. The active list pops at the next edge.
- recoveryReq, exceptionReq and recoveryPc are registered. They assert in cycle t+1 for the event detected in cycle t, for exactly one cycle.
- busy goes high in cycle t+1 and stays high through the cycle in which recoveryDone is sampled.
- The earliest return to retiring is the cycle after recoveryDone.
- Reset values: state NORMAL, recoveryReq 0, exceptionReq 0, recoveryPc 0, retiredCount 0, busy 0. The combinational outputs are 0 while rst is low.
- Reset asserted mid-RECOVER: return immediately to NORMAL and cancel any pending pulse.
- An empty active list (headValid all 0) gives popCount 0 with no side effects.

## Test plan
- Retire two ALU ops: COMMIT_WIDTH=2, both lanes valid, executed and writeReg, prevDst 5 and 9. Expect popCount=2, releaseReg 5 and 9, and retiredCount to increase by 2.
- Partial head: lane 0 executed, lane 1 valid but not executed. Expect popCount=1 and no pulse. Next cycle with lane 1 executed, expect popCount=1.
- Mispredict: lane 0 is a mispredicted branch at PC 0x1000, lane 1 is valid and executed. Expect popCount=1, then recoveryReq=1 and recoveryPc=0x1000 for one cycle. busy stays high and popCount stays 0 until recoveryDone; retirement resumes the cycle after.
- Exception: lane 0 is a retiring store, lane 1 has headException at PC 0x2004. Expect popCount=1 and storeCommit=01, then exceptionReq=1 and recoveryPc=0x2004 for one cycle.
- Stall, wrap and reset:
  - stall=1 with all lanes ready: expect popCount=0.
  - retiredCount preloaded near 2^64-1, then two retirements: expect it to wrap to 0.
  - rst low during RECOVER: expect busy=0 and no pulses.
